// File: rtl/tpu_pkg.sv
// Shared constants, feeder state encoding and the row-count saturation helper
// for the unified-buffer-to-systolic-array feeder.
package tpu_pkg;

    localparam int LANES  = 16;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 9;
    localparam int LANE_W = DATA_W;
    localparam int ROW_W  = LANES * DATA_W;

    localparam logic [LEN_W-1:0] MAX_ROWS = 9'd256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] n);
        return (n > MAX_ROWS) ? MAX_ROWS : n;
    endfunction

endpackage

// File: rtl/lane_skew_delay.sv
// One lane of the diagonal skew: a capture register followed by DEPTH extra
// delay stages. Data is zeroed whenever the lane is not valid.
module lane_skew_delay
    import tpu_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LANE_W-1:0] i_data,
    input  logic              i_valid,
    output logic [LANE_W-1:0] o_data,
    output logic              o_valid
);

    logic [LANE_W-1:0] r_data [0:DEPTH];
    logic [DEPTH:0]    r_valid;

    // Capture stage plus shift chain for data and valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k <= DEPTH; k++) begin
                r_data[k]  <= '0;
                r_valid[k] <= 1'b0;
            end
        end else begin
            r_data[0]  <= i_valid ? i_data : '0;
            r_valid[0] <= i_valid;
            for (int k = 1; k <= DEPTH; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    assign o_data  = r_data[DEPTH];
    assign o_valid = r_valid[DEPTH];

endmodule

// File: rtl/ub_skew_feeder.sv
// Streams a run of unified-buffer rows into the systolic array row edge,
// unpacking each row into lanes and skewing lane i by i cycles.
module ub_skew_feeder
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  row_count,
    output logic              busy,
    output logic              done,
    output logic              ub_enb,
    output logic [ADDR_W-1:0] ub_addrb,
    input  logic [ROW_W-1:0]  ub_doutb,
    output logic [ROW_W-1:0]  sa_data,
    output logic [LANES-1:0]  sa_valid
);

    feeder_state_e     r_state;
    feeder_state_e     w_state_nxt;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_ub_addrb;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [LEN_W-1:0]  w_len;
    logic              r_ub_enb;
    logic              r_busy;
    logic              r_done;

    assign w_len = sat_len(row_count);

    // Next-state logic; r_cnt counts remaining reads in READ and remaining
    // skew-drain cycles in DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_ub_addrb;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_len == 9'd0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_READ;
                        w_cnt_nxt   = w_len;
                        w_addr_nxt  = base_addr;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (r_cnt == 9'd1) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = LEN_W'(LANES - 1);
                end else begin
                    w_cnt_nxt  = r_cnt - 9'd1;
                    w_addr_nxt = r_ub_addrb + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == 9'd0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 9'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 9'd0;
            r_ub_addrb <= 8'd0;
            r_ub_enb   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ub_addrb <= w_addr_nxt;
            r_ub_enb   <= (w_state_nxt == ST_READ);
            r_busy     <= (w_state_nxt == ST_READ) || (w_state_nxt == ST_DRAIN);
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    assign ub_enb   = r_ub_enb;
    assign ub_addrb = r_ub_addrb;
    assign busy     = r_busy;
    assign done     = r_done;

    // Read data for the address shown this cycle arrives at the next edge,
    // so the current enable qualifies the lane capture.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_skew_delay #(
            .DEPTH (g)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .i_data  (ub_doutb[g*LANE_W +: LANE_W]),
            .i_valid (r_ub_enb),
            .o_data  (sa_data[g*LANE_W +: LANE_W]),
            .o_valid (sa_valid[g])
        );
    end

endmodule

// File: doc/ub_skew_feeder.md
Name: ub_skew_feeder

Overview:
- Reads a contiguous run of 128-bit rows from the 256x16x8b unified buffer and unpacks each row into 16 8-bit lanes.
- Applies diagonal skew (lane i delayed i cycles) and drives the row-input edge of the 16-wide systolic array.
- Started by the controller with base/length; reports busy/done.
- Sits directly downstream of the unified buffer read port (enb/addrb/doutb).

Parameters:
- LANES, 16, number of 8-bit lanes per buffer row / systolic rows
- DATA_W, 8, bits per lane
- ADDR_W, 8, buffer address width (256 rows)
- LEN_W, 9, width of row-count input (0..256)

Ports:
- clk  in  1  single clock; all block logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first buffer row to read
- row_count  in  LEN_W  number of rows to stream (0..256)
- busy  out  1  high from first cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- ub_enb  out  1  buffer read enable
- ub_addrb  out  ADDR_W  buffer read address
- ub_doutb  in  LANES*DATA_W  buffer read data (valid one rising edge after addr/enb)
- sa_data  out  LANES*DATA_W  skewed lane data; lane i = bits [8i+7:8i]
- sa_valid  out  LANES  per-lane valid

Behaviour:
- Reset (reset_n low at rising edge): state IDLE; busy, done, ub_enb, sa_valid = 0; ub_addrb, sa_data, all skew registers = 0. Reset mid-operation aborts immediately with no done pulse.
- Buffer timing: the buffer samples address on falling edge, so data for addr presented in cycle n is captured by this block at rising edge n+1 (1-cycle read latency).
- States: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 at edge S latches base/row_count. row_count=0 goes to DONE (done in cycle S+1, no reads, busy stays 0). Otherwise goes to READ. start is ignored in any other state.
- READ: in cycles S+1..S+L (L=row_count), ub_enb=1 and ub_addrb=base+k in cycle S+1+k. Address increments mod 256 (0xFF wraps to 0x00). After the last address, go to DRAIN with ub_enb=0.
- Lane 0 of row k is registered from ub_doutb and visible in cycle S+2+k. Lane i of row k is visible in cycle S+2+k+i with sa_valid[i]=1.
- Inactive lanes: sa_valid[i]=0 and sa_data lane i = 0.
- DRAIN: lasts until lane 15 of row L-1 has been presented (cycle S+L+16), then DONE.
- DONE: done=1 for one cycle (S+L+17), busy=0 in that cycle, then IDLE. A start on the done cycle is ignored; the earliest new start is accepted the cycle after.
- busy=1 in cycles S+1..S+L+16.
- No backpressure: the array consumes every cycle.
- row_count > 256 is saturated to 256.

Decomposition:
- Shared package (tpu_pkg): LANES, DATA_W, ADDR_W, LEN_W constants; feeder state enum; lane slice width constant.
- Sub-module lane_skew_delay:
  - parameter DEPTH; data+valid shift register with synchronous active-low reset; DEPTH=0 passes through the register stage.
  - Instantiated LANES times, with DEPTH=i for lane i.

Test Plan:
- Reset mid-READ (L=10, reset_n low at S+4) -> next cycle: all outputs 0, state IDLE, no done; fresh start afterwards behaves normally.
- base=0x10, L=1, row 0x10 = bytes 0x00..0x0F -> ub_enb only in S+1 with addr 0x10; lane i=0x0i with valid in cycle S+2+i; done at S+18; busy S+1..S+17.
- base=0xFE, L=4 -> ub_addrb sequence 0xFE,0xFF,0x00,0x01; lane 5 emits rows in order in cycles S+7..S+10.
- L=0 -> no ub_enb, busy never 1, done in S+1.
- L=256, base=0x00 -> 256 consecutive reads; sa_valid = all-ones in cycles S+17..S+257; done at S+273.
- start pulsed during busy and again on the done cycle -> both ignored; addresses unchanged; start the cycle after done is accepted.
